// File: rtl/sc_fsm_act.sv
// sc_fsm_act: multi-channel stochastic-computing activation unit.
//
// Each of the CH lanes holds a saturating up/down counter that climbs on a 1
// and falls on a 0 of its input bitstream. The output stream is a Moore decode
// of that counter, so x reaches y only through the registered state.
// The mode input picks one of three decodes:
//   00 / 11 : tanh   -> y = MSB of the state  (s >= N/2)
//   01      : exp    -> y = (s < N - EXP_G)
//   10      : bypass -> y = x delayed by one enabled cycle
// Every lane's counter runs in every mode. The mode input only selects the
// decode, so a mode change shows on y in the same cycle and the state is not
// affected.
//
// Ports
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous, active-high; state -> INIT, bypass -> 0
//   en      in   1   advance enable for counters and bypass flops
//   clr     in   1   synchronous re-initialise; wins over en and x
//   mode    in   2   output decode select
//   x       in   CH  input bitstreams, one bit per lane per cycle
//   y       out  CH  output bitstreams
//   sat_hi  out  CH  lane state == N-1
//   sat_lo  out  CH  lane state == 0
module sc_fsm_act #(
  parameter int unsigned CH      = 4,
  parameter int unsigned STATE_W = 4,
  parameter int unsigned EXP_G   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [1:0]      mode,
  input  logic [CH-1:0]   x,
  output logic [CH-1:0]   y,
  output logic [CH-1:0]   sat_hi,
  output logic [CH-1:0]   sat_lo
);

  localparam int unsigned N = 2 ** STATE_W;

  // INIT = N/2 - 1: the state just below the tanh threshold.
  localparam logic [STATE_W-1:0] S_INIT = {1'b0, {(STATE_W-1){1'b1}}};
  localparam logic [STATE_W-1:0] S_MAX  = '1;
  localparam logic [STATE_W-1:0] S_MIN  = '0;
  localparam logic [STATE_W-1:0] S_ONE  = STATE_W'(1);
  // exp threshold N-G. Because G >= 1, it always fits in STATE_W bits.
  localparam logic [STATE_W-1:0] EXP_TH = STATE_W'(N - EXP_G);

  typedef enum logic [1:0] {
    MODE_TANH = 2'b00,
    MODE_EXP  = 2'b01,
    MODE_BYP  = 2'b10,
    MODE_RSV  = 2'b11
  } mode_e;

  logic [STATE_W-1:0] s_q [CH];
  logic [STATE_W-1:0] s_d [CH];
  logic [CH-1:0]      byp_q;
  logic [CH-1:0]      byp_d;
  mode_e              mode_sel;

  // Next-state logic: clr has priority, then en. The counter saturates at
  // both ends and never wraps.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      s_d[i] = s_q[i];
      if (clr) begin
        s_d[i] = S_INIT;
      end else if (en) begin
        if (x[i]) begin
          if (s_q[i] != S_MAX) s_d[i] = s_q[i] + S_ONE;
        end else begin
          if (s_q[i] != S_MIN) s_d[i] = s_q[i] - S_ONE;
        end
      end
    end
  end

  always_comb begin
    byp_d = byp_q;
    if (clr)     byp_d = '0;
    else if (en) byp_d = x;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CH; i++) s_q[i] <= S_INIT;
      byp_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) s_q[i] <= s_d[i];
      byp_q <= byp_d;
    end
  end

  // Moore decode taken from the registers only. The reserved code 11 falls
  // through to tanh.
  assign mode_sel = mode_e'(mode);

  always_comb begin
    y      = '0;
    sat_hi = '0;
    sat_lo = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      sat_hi[i] = (s_q[i] == S_MAX);
      sat_lo[i] = (s_q[i] == S_MIN);
      unique case (mode_sel)
        MODE_EXP: y[i] = (s_q[i] < EXP_TH);
        MODE_BYP: y[i] = byp_q[i];
        default:  y[i] = s_q[i][STATE_W-1];
      endcase
    end
  end

endmodule

// File: tb/tb_sc_fsm_act.sv
// Directed bench for sc_fsm_act with CH=4, STATE_W=4, EXP_G=2.
// The expected values in the directed steps are worked out by hand. A
// reference counter model is used in the statistical phase.
module tb_sc_fsm_act;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] sat_hi;
  logic [3:0] sat_lo;

  int n_checks = 0;
  int n_errors = 0;

  // reference state, used in the statistical phase
  int s_m [4];

  sc_fsm_act #(.CH(4), .STATE_W(4), .EXP_G(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .clr    (clr),
    .mode   (mode),
    .x      (x),
    .y      (y),
    .sat_hi (sat_hi),
    .sat_lo (sat_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive x, take one rising edge, advance the reference model, then settle
  // for 1 time unit so the outputs can be sampled away from the edge.
  task automatic step(input logic [3:0] xv);
    x = xv;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (clr)           s_m[i] = 7;
      else if (en && xv[i]) s_m[i] = (s_m[i] < 15) ? s_m[i] + 1 : 15;
      else if (en)       s_m[i] = (s_m[i] > 0) ? s_m[i] - 1 : 0;
    end
    #1;
  endtask

  task automatic steps(input int n, input logic [3:0] xv);
    for (int k = 0; k < n; k++) step(xv);
  endtask

  // Run n Bernoulli(pct/100) cycles on every lane. Returns the total number
  // of ones seen on y and the number of cycles where y disagreed with the
  // reference model.
  task automatic stat_run(input int n, input int pct, output int ones, output int mism);
    logic [3:0] xv;
    logic [3:0] ym;
    ones = 0;
    mism = 0;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) xv[i] = ($urandom_range(0, 99) < pct);
      step(xv);
      for (int i = 0; i < 4; i++) begin
        ym[i] = (s_m[i] >= 8);
        if (y[i]) ones++;
      end
      if (y !== ym) mism++;
    end
  endtask

  int ones;
  int mism;
  int dens;

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00; x = 4'b0000;
    for (int i = 0; i < 4; i++) s_m[i] = 7;

    // 1. reset state and the three decodes
    #1;
    chk("rst_y_tanh", y, 4'b0000);
    chk("rst_sat_hi", sat_hi, 4'b0000);
    chk("rst_sat_lo", sat_lo, 4'b0000);
    mode = 2'b01; #1;
    chk("rst_y_exp", y, 4'b1111);
    mode = 2'b10; #1;
    chk("rst_y_byp", y, 4'b0000);
    mode = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;

    // 2. tanh up-count on lane 0; lanes 1..3 count down
    step(4'b0001);                        // s = 8,6,6,6
    chk("up1_y", y, 4'b0001);
    chk("up1_sat_lo", sat_lo, 4'b0000);
    steps(6, 4'b0001);                    // s = 14,0,0,0
    chk("dn7_sat_lo", sat_lo, 4'b1110);
    chk("up7_sat_hi", sat_hi, 4'b0000);
    steps(4, 4'b0001);                    // s0 saturates at 15
    chk("up11_sat_hi", sat_hi, 4'b0001);
    chk("up11_y", y, 4'b0001);
    step(4'b0000);                        // s0 = 14
    chk("hi_dn_y", y, 4'b0001);
    chk("hi_dn_sat_hi", sat_hi, 4'b0000);
    chk("hi_dn_sat_lo", sat_lo, 4'b1110);

    // 3. low saturation then recovery on lane 1
    steps(20, 4'b0000);
    chk("lo20_sat_lo", sat_lo, 4'b1111);
    chk("lo20_y", y, 4'b0000);
    steps(7, 4'b0010);                    // s1 = 7
    chk("rec7_y", y, 4'b0000);
    chk("rec7_sat_lo", sat_lo, 4'b1101);
    step(4'b0010);                        // s1 = 8
    chk("rec8_y", y, 4'b0010);

    // 4. exp threshold on lane 2 (threshold 14)
    mode = 2'b01;
    clr  = 1'b1;
    step(4'b1111);                        // all back to 7
    clr  = 1'b0;
    chk("clr_exp_y", y, 4'b1111);
    steps(6, 4'b0100);                    // s2 = 13, others 1
    chk("exp13_y", y, 4'b1111);
    step(4'b0100);                        // s2 = 14
    chk("exp14_y", y, 4'b1011);
    step(4'b0000);                        // s2 = 13
    chk("exp13b_y", y, 4'b1111);

    // 5. control priority, tanh decode; s = 0,0,13,0
    mode = 2'b00;
    en   = 1'b0;
    steps(10, 4'b1111);
    chk("hold_y", y, 4'b0100);
    chk("hold_sat_lo", sat_lo, 4'b1011);
    en  = 1'b1;
    clr = 1'b1;
    step(4'b1111);
    clr = 1'b0;
    chk("clr_y", y, 4'b0000);
    chk("clr_sat_lo", sat_lo, 4'b0000);
    chk("clr_sat_hi", sat_hi, 4'b0000);
    steps(3, 4'b1111);                    // all 10
    chk("pre_rst_y", y, 4'b1111);
    #2 reset = 1'b1;                      // between edges
    #1;
    chk("async_rst_y", y, 4'b0000);
    chk("async_rst_sat", sat_hi | sat_lo, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) s_m[i] = 7;

    steps(9, 4'b0001);                    // s = 15,0,0,0
    step(4'b1111);                        // s = 15,1,1,1; bypass = 1111
    chk("sw_tanh_y", y, 4'b0001);
    chk("sw_sat_hi", sat_hi, 4'b0001);
    mode = 2'b10; #1;
    chk("sw_byp_y", y, 4'b1111);
    en = 1'b0;
    step(4'b0000);
    chk("byp_hold_y", y, 4'b1111);
    en = 1'b1;
    step(4'b0101);
    chk("byp_upd_y", y, 4'b0101);
    mode = 2'b00; #1;
    chk("sw_back_y", y, 4'b0001);
    mode = 2'b11; #1;
    chk("rsv_y", y, 4'b0001);
    mode = 2'b00;

    // 6. statistical tanh on all four lanes
    clr = 1'b1;
    step(4'b0000);
    clr = 1'b0;
    stat_run(64, 55, ones, mism);
    stat_run(40000, 55, ones, mism);
    dens = (ones * 10) / 1600;            // per mille over 4 x 40000 samples
    n_checks++;
    assert (mism == 0) else begin
      n_errors++;
      $error("FAIL stat55_model: observed %0d mismatching cycles expected 0", mism);
    end
    n_checks++;
    assert (dens >= 782 && dens <= 882) else begin
      n_errors++;
      $error("FAIL stat55_density: observed %0d permille expected 832 +/- 50", dens);
    end
    stat_run(64, 50, ones, mism);
    stat_run(40000, 50, ones, mism);
    dens = (ones * 10) / 1600;
    n_checks++;
    assert (mism == 0) else begin
      n_errors++;
      $error("FAIL stat50_model: observed %0d mismatching cycles expected 0", mism);
    end
    n_checks++;
    assert (dens >= 450 && dens <= 550) else begin
      n_errors++;
      $error("FAIL stat50_density: observed %0d permille expected 500 +/- 50", dens);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
